// File: rtl/pq_req_sched.sv
// Request scheduler and one-entry response buffer in front of the register-array priority queue.
package pq_pkg;
    localparam int unsigned KEY_WIDTH = 8;
    localparam int unsigned VAL_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_ENQ     = 2'b01,
        OP_DEQ     = 2'b10,
        OP_ENQ_DEQ = 2'b11
    } pq_op_e;
endpackage

module pq_req_sched #(
    parameter int unsigned KEY_WIDTH  = pq_pkg::KEY_WIDTH,
    parameter int unsigned VAL_WIDTH  = pq_pkg::VAL_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] req_kv,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] rsp_kv,
    output logic                           pq_enq,
    output logic                           pq_deq,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
    input  logic                           pq_busy,
    input  logic                           pq_empty,
    input  logic                           pq_full,
    output logic [7:0]                     drop_cnt
);
    localparam int unsigned W  = KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_GAP} state_e;

    state_e          state_q, state_d;
    pq_pkg::pq_op_e  op_mem [FIFO_DEPTH];
    logic [W-1:0]    kv_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_ready_q;
    logic            push, pop, drop, fifo_empty;
    pq_pkg::pq_op_e  head_op;
    logic [W-1:0]    head_kv;
    logic            head_enq, head_deq, head_illegal, rsp_stall;
    logic            issue_enq_d, issue_deq_d;
    logic            pq_enq_q, pq_deq_q;
    logic [W-1:0]    pq_kvi_q;
    logic            rsp_valid_q, rsp_set;
    logic [W-1:0]    rsp_kv_q;
    logic [7:0]      drop_cnt_q;

    assign push       = req_valid && req_ready_q;
    assign fifo_empty = (cnt_q == '0);
    assign head_op    = op_mem[rd_ptr_q];
    assign head_kv    = kv_mem[rd_ptr_q];
    assign head_enq   = (head_op == pq_pkg::OP_ENQ) || (head_op == pq_pkg::OP_ENQ_DEQ);
    assign head_deq   = (head_op == pq_pkg::OP_DEQ) || (head_op == pq_pkg::OP_ENQ_DEQ);
    // A replace on a full PQ keeps occupancy, so only a plain ENQ is blocked by pq_full.
    assign head_illegal = (head_deq && pq_empty) || ((head_op == pq_pkg::OP_ENQ) && pq_full);
    assign rsp_stall    = head_deq && rsp_valid_q && !rsp_ready;
    assign rsp_set      = (state_q == S_ISSUE) && pq_deq_q;

    // Occupancy next value; push and pop together leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Next-state, pop/drop decisions and command pulse requests.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        drop        = 1'b0;
        issue_enq_d = 1'b0;
        issue_deq_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else if (head_op == pq_pkg::OP_NOP) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end else if (head_illegal) begin
                    pop     = 1'b1;
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else if (!rsp_stall && pq_busy) begin
                    issue_enq_d = head_enq;
                    issue_deq_d = head_deq;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pop     = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = fifo_empty ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FIFO pointers, occupancy and registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q       <= cnt_d;
            req_ready_q <= (cnt_d != CW'(FIFO_DEPTH));
        end
    end

    // FIFO storage; validity is tracked by the occupancy counter, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= pq_pkg::pq_op_e'(req_op);
            kv_mem[wr_ptr_q] <= req_kv;
        end
    end

    // Registered PQ command pulses and input word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq_enq_q <= 1'b0;
            pq_deq_q <= 1'b0;
            pq_kvi_q <= '0;
        end else begin
            pq_enq_q <= issue_enq_d;
            pq_deq_q <= issue_deq_d;
            if (issue_enq_d) pq_kvi_q <= head_kv;
        end
    end

    // Response register; a new capture wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_kv_q    <= '0;
        end else if (rsp_set) begin
            rsp_valid_q <= 1'b1;
            rsp_kv_q    <= pq_kvo;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Saturating count of filtered requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_kv    = rsp_kv_q;
    assign pq_enq    = pq_enq_q;
    assign pq_deq    = pq_deq_q;
    assign pq_kvi    = pq_kvi_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pq_req_sched.sv
// Directed bench for pq_req_sched with a behavioural min-key priority queue.
`timescale 1ns/1ps
module tb_pq_req_sched;
    localparam int unsigned KW = 8;
    localparam int unsigned VW = 8;
    localparam int unsigned W  = KW + VW;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PQ_CAP = 4;
    localparam logic [1:0] OP_NOP = 2'b00, OP_ENQ = 2'b01, OP_DEQ = 2'b10, OP_RPL = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = OP_NOP;
    logic [W-1:0] req_kv = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_kv;
    logic         pq_enq, pq_deq;
    logic [W-1:0] pq_kvi;
    logic [W-1:0] pq_kvo = '0;
    logic         pq_busy = 1'b0;
    logic         pq_empty = 1'b1;
    logic         pq_full = 1'b0;
    logic [7:0]   drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pq_req_sched #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_kv(req_kv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
        .pq_busy(pq_busy), .pq_empty(pq_empty), .pq_full(pq_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural PQ: commands seen in cycle N take effect after the edge ending cycle N.
    logic [W-1:0] pq_q[$];
    logic         e_l = 1'b0, d_l = 1'b0;
    logic [W-1:0] kv_l = '0;

    always @(posedge clk) begin
        pq_busy <= ~pq_busy;
        e_l     <= pq_enq;
        d_l     <= pq_deq;
        kv_l    <= pq_kvi;
    end

    always @(negedge clk) begin
        int pos;
        if (d_l && pq_q.size() > 0) void'(pq_q.pop_front());
        if (e_l) begin
            pos = pq_q.size();
            for (int i = 0; i < pq_q.size(); i++) begin
                if (pq_q[i][W-1:VW] > kv_l[W-1:VW]) begin
                    pos = i;
                    break;
                end
            end
            pq_q.insert(pos, kv_l);
        end
        pq_kvo   = (pq_q.size() > 0) ? pq_q[0] : '0;
        pq_empty = (pq_q.size() == 0);
        pq_full  = (pq_q.size() >= PQ_CAP);
    end

    // Pulse and response logs.
    typedef struct {
        int           cyc;
        logic         e;
        logic         d;
        logic [W-1:0] kv;
        logic         busy_before;
    } pulse_t;
    pulse_t       plog[$];
    logic [W-1:0] rlog[$];
    int           cyc = 0;
    logic         busy_last = 1'b0;

    always @(negedge clk) begin
        pulse_t p;
        cyc++;
        if (pq_enq || pq_deq) begin
            p.cyc = cyc; p.e = pq_enq; p.d = pq_deq; p.kv = pq_kvi; p.busy_before = busy_last;
            plog.push_back(p);
        end
        if (rst_n && rsp_valid && rsp_ready) rlog.push_back(rsp_kv);
        busy_last = pq_busy;
    end

    function automatic logic [W-1:0] kv(input int k, input int v);
        return {KW'(k), VW'(v)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] data);
        int n;
        n = 0;
        req_valid = 1'b1; req_op = op; req_kv = data;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (!req_ready) begin
            n_err++;
            $display("FAIL send_timeout: req_ready=%0b required 1", req_ready);
        end else begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_kv !== '0) begin n_err++; $display("FAIL rst_rsp_kv: got %h want 0", rsp_kv); end
        n_cmp++; if (pq_enq !== 1'b0 || pq_deq !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got enq=%b deq=%b want 0/0", pq_enq, pq_deq); end
        n_cmp++; if (pq_kvi !== '0) begin n_err++; $display("FAIL rst_pq_kvi: got %h want 0", pq_kvi); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_enq_burst();
        int p0;
        logic [W-1:0] exp_kv[4];
        exp_kv[0] = kv(8, 14); exp_kv[1] = kv(11, 11); exp_kv[2] = kv(9, 9); exp_kv[3] = kv(12, 12);
        p0 = plog.size();
        for (int i = 0; i < 4; i++) send(OP_ENQ, exp_kv[i]);
        tick(30);
        n_cmp++; if (plog.size() - p0 != 4) begin n_err++; $display("FAIL enq_pulse_count: got %0d want 4", plog.size() - p0); end
        for (int i = 0; i < 4; i++) begin
            if (p0 + i < plog.size()) begin
                n_cmp++;
                if (plog[p0+i].e !== 1'b1 || plog[p0+i].d !== 1'b0 || plog[p0+i].kv !== exp_kv[i]) begin
                    n_err++;
                    $display("FAIL enq_pulse%0d: got e=%b d=%b kv=%h want 1/0/%h", i, plog[p0+i].e, plog[p0+i].d, plog[p0+i].kv, exp_kv[i]);
                end
            end
        end
    endtask

    task automatic test_deq();
        int r0;
        r0 = rlog.size();
        rsp_ready = 1'b1;
        send(OP_DEQ, '0);
        send(OP_DEQ, '0);
        tick(30);
        n_cmp++; if (rlog.size() - r0 != 2) begin n_err++; $display("FAIL deq_rsp_count: got %0d want 2", rlog.size() - r0); end
        if (rlog.size() - r0 >= 2) begin
            n_cmp++; if (rlog[r0] !== kv(8, 14)) begin n_err++; $display("FAIL deq_rsp0: got %h want %h", rlog[r0], kv(8, 14)); end
            n_cmp++; if (rlog[r0+1] !== kv(9, 9)) begin n_err++; $display("FAIL deq_rsp1: got %h want %h", rlog[r0+1], kv(9, 9)); end
        end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL deq_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_replace();
        int p0, r0;
        p0 = plog.size(); r0 = rlog.size();
        send(OP_RPL, kv(13, 13));
        send(OP_RPL, kv(1, 1));
        tick(30);
        n_cmp++; if (plog.size() - p0 != 2) begin n_err++; $display("FAIL rpl_pulse_count: got %0d want 2", plog.size() - p0); end
        if (plog.size() - p0 >= 2) begin
            n_cmp++; if (!(plog[p0].e && plog[p0].d) || plog[p0].kv !== kv(13, 13)) begin n_err++; $display("FAIL rpl_pulse0: got e=%b d=%b kv=%h want 1/1/%h", plog[p0].e, plog[p0].d, plog[p0].kv, kv(13, 13)); end
            n_cmp++; if (!(plog[p0+1].e && plog[p0+1].d) || plog[p0+1].kv !== kv(1, 1)) begin n_err++; $display("FAIL rpl_pulse1: got e=%b d=%b kv=%h want 1/1/%h", plog[p0+1].e, plog[p0+1].d, plog[p0+1].kv, kv(1, 1)); end
        end
        n_cmp++; if (rlog.size() - r0 != 2) begin n_err++; $display("FAIL rpl_rsp_count: got %0d want 2", rlog.size() - r0); end
        if (rlog.size() - r0 >= 2) begin
            n_cmp++; if (rlog[r0] !== kv(11, 11)) begin n_err++; $display("FAIL rpl_rsp0: got %h want %h", rlog[r0], kv(11, 11)); end
            n_cmp++; if (rlog[r0+1] !== kv(12, 12)) begin n_err++; $display("FAIL rpl_rsp1: got %h want %h", rlog[r0+1], kv(12, 12)); end
        end
    endtask

    task automatic test_illegal();
        int p0, r0;
        p0 = plog.size(); r0 = rlog.size();
        send(OP_DEQ, '0);
        send(OP_DEQ, '0);
        send(OP_DEQ, '0);
        tick(30);
        n_cmp++; if (plog.size() - p0 != 2) begin n_err++; $display("FAIL ill_pulse_count: got %0d want 2", plog.size() - p0); end
        n_cmp++; if (rlog.size() - r0 != 2) begin n_err++; $display("FAIL ill_rsp_count: got %0d want 2", rlog.size() - r0); end
        if (rlog.size() - r0 >= 2) begin
            n_cmp++; if (rlog[r0] !== kv(1, 1) || rlog[r0+1] !== kv(13, 13)) begin n_err++; $display("FAIL ill_drain: got %h,%h want %h,%h", rlog[r0], rlog[r0+1], kv(1, 1), kv(13, 13)); end
        end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ill_drop_cnt: got %0d want 1", drop_cnt); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL ill_rsp_valid: got %b want 0", rsp_valid); end
        send(OP_ENQ, kv(10, 10));
        tick(20);
        n_cmp++; if (plog.size() - p0 != 3) begin n_err++; $display("FAIL ill_enq_count: got %0d want 3", plog.size() - p0); end
        else if (plog[p0+2].e !== 1'b1 || plog[p0+2].kv !== kv(10, 10)) begin n_err++; $display("FAIL ill_enq_pulse: got e=%b kv=%h want 1/%h", plog[p0+2].e, plog[p0+2].kv, kv(10, 10)); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ill_drop_hold: got %0d want 1", drop_cnt); end
    endtask

    task automatic test_rsp_stall();
        int p0, r0;
        send(OP_ENQ, kv(5, 5));
        send(OP_ENQ, kv(7, 7));
        tick(20);
        rsp_ready = 1'b0;
        r0 = rlog.size();
        send(OP_DEQ, '0);
        tick(20);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_kv !== kv(5, 5)) begin n_err++; $display("FAIL stall_first_rsp: got v=%b kv=%h want 1/%h", rsp_valid, rsp_kv, kv(5, 5)); end
        p0 = plog.size();
        send(OP_DEQ, '0);
        send(OP_DEQ, '0);
        tick(20);
        n_cmp++; if (plog.size() != p0) begin n_err++; $display("FAIL stall_no_pulse: got %0d pulses want 0", plog.size() - p0); end
        n_cmp++; if (rsp_kv !== kv(5, 5)) begin n_err++; $display("FAIL stall_rsp_hold: got %h want %h", rsp_kv, kv(5, 5)); end
        rsp_ready = 1'b1;
        tick(40);
        n_cmp++; if (rlog.size() - r0 != 3) begin n_err++; $display("FAIL stall_rsp_count: got %0d want 3", rlog.size() - r0); end
        else if (rlog[r0] !== kv(5, 5) || rlog[r0+1] !== kv(7, 7) || rlog[r0+2] !== kv(10, 10)) begin
            n_err++; $display("FAIL stall_rsp_order: got %h,%h,%h want %h,%h,%h", rlog[r0], rlog[r0+1], rlog[r0+2], kv(5, 5), kv(7, 7), kv(10, 10));
        end
        n_cmp++; if (plog.size() - p0 != 2) begin n_err++; $display("FAIL stall_pulse_count: got %0d want 2", plog.size() - p0); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_rsp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fill_reset();
        int p0;
        rsp_ready = 1'b0;
        send(OP_ENQ, kv(20, 20));
        send(OP_ENQ, kv(21, 21));
        send(OP_DEQ, '0);
        tick(20);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_kv !== kv(20, 20)) begin n_err++; $display("FAIL fill_rsp: got v=%b kv=%h want 1/%h", rsp_valid, rsp_kv, kv(20, 20)); end
        p0 = plog.size();
        for (int i = 0; i < DEPTH; i++) send(OP_DEQ, '0);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_low: got %b want 0", req_ready); end
        req_valid = 1'b1; req_op = OP_ENQ; req_kv = kv(99, 99);
        tick(5);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_hold: got %b want 0", req_ready); end
        n_cmp++; if (plog.size() != p0) begin n_err++; $display("FAIL fill_no_pulse: got %0d pulses want 0", plog.size() - p0); end
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_kv !== '0) begin n_err++; $display("FAIL mid_rst_rsp: got v=%b kv=%h want 0/0", rsp_valid, rsp_kv); end
        n_cmp++; if (pq_enq !== 1'b0 || pq_deq !== 1'b0 || pq_kvi !== '0) begin n_err++; $display("FAIL mid_rst_cmd: got e=%b d=%b kvi=%h want 0/0/0", pq_enq, pq_deq, pq_kvi); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_drop: got %0d want 0", drop_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        p0 = plog.size();
        tick(20);
        n_cmp++; if (plog.size() != p0) begin n_err++; $display("FAIL post_rst_fifo_empty: got %0d pulses want 0", plog.size() - p0); end
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid); end
    endtask

    task automatic test_pulse_rules();
        for (int i = 0; i < plog.size(); i++) begin
            n_cmp++;
            if (plog[i].busy_before !== 1'b1) begin n_err++; $display("FAIL pulse%0d_phase: busy before pulse=%b want 1", i, plog[i].busy_before); end
            if (i > 0) begin
                n_cmp++;
                if (plog[i].cyc - plog[i-1].cyc < 3) begin n_err++; $display("FAIL pulse%0d_spacing: got %0d cycles want >=3", i, plog[i].cyc - plog[i-1].cyc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enq_burst();
        test_deq();
        test_replace();
        test_illegal();
        test_rsp_stall();
        test_fill_reset();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
